// File: rtl/multiplex.sv
// multiplex: registered 32-way, 32-bit word selector on the register-file
// read path. Output = R[Signal], registered on clk, synchronous active-high
// reset to zero.
//
// Optional build macro MULTIPLEX_INREG_EN adds an input register stage
// (Signal and R0..R31), raising the latency from 1 to 2 cycles. The port
// list and the reset behaviour are the same in both builds.
module multiplex (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] R0,
    input  logic [31:0] R1,
    input  logic [31:0] R2,
    input  logic [31:0] R3,
    input  logic [31:0] R4,
    input  logic [31:0] R5,
    input  logic [31:0] R6,
    input  logic [31:0] R7,
    input  logic [31:0] R8,
    input  logic [31:0] R9,
    input  logic [31:0] R10,
    input  logic [31:0] R11,
    input  logic [31:0] R12,
    input  logic [31:0] R13,
    input  logic [31:0] R14,
    input  logic [31:0] R15,
    input  logic [31:0] R16,
    input  logic [31:0] R17,
    input  logic [31:0] R18,
    input  logic [31:0] R19,
    input  logic [31:0] R20,
    input  logic [31:0] R21,
    input  logic [31:0] R22,
    input  logic [31:0] R23,
    input  logic [31:0] R24,
    input  logic [31:0] R25,
    input  logic [31:0] R26,
    input  logic [31:0] R27,
    input  logic [31:0] R28,
    input  logic [31:0] R29,
    input  logic [31:0] R30,
    input  logic [31:0] R31,
    input  logic [4:0]  Signal,
    output logic [31:0] Output
);

    // Port words gathered into an array so the mux can index them.
    logic [31:0] port_words [32];

    assign port_words[0]  = R0;
    assign port_words[1]  = R1;
    assign port_words[2]  = R2;
    assign port_words[3]  = R3;
    assign port_words[4]  = R4;
    assign port_words[5]  = R5;
    assign port_words[6]  = R6;
    assign port_words[7]  = R7;
    assign port_words[8]  = R8;
    assign port_words[9]  = R9;
    assign port_words[10] = R10;
    assign port_words[11] = R11;
    assign port_words[12] = R12;
    assign port_words[13] = R13;
    assign port_words[14] = R14;
    assign port_words[15] = R15;
    assign port_words[16] = R16;
    assign port_words[17] = R17;
    assign port_words[18] = R18;
    assign port_words[19] = R19;
    assign port_words[20] = R20;
    assign port_words[21] = R21;
    assign port_words[22] = R22;
    assign port_words[23] = R23;
    assign port_words[24] = R24;
    assign port_words[25] = R25;
    assign port_words[26] = R26;
    assign port_words[27] = R27;
    assign port_words[28] = R28;
    assign port_words[29] = R29;
    assign port_words[30] = R30;
    assign port_words[31] = R31;

    // Words and select actually seen by the mux (ports or registered copies).
    logic [31:0] mux_words [32];
    logic [4:0]  mux_sel;
    logic [31:0] sel_word;

`ifdef MULTIPLEX_INREG_EN
    logic [31:0] words_q [32];
    logic [4:0]  sel_q;

    // Input stage: capture select and all candidate words, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= 5'd0;
            for (int i = 0; i < 32; i++) begin
                words_q[i] <= 32'h0000_0000;
            end
        end else begin
            sel_q <= Signal;
            for (int i = 0; i < 32; i++) begin
                words_q[i] <= port_words[i];
            end
        end
    end

    assign mux_words = words_q;
    assign mux_sel   = sel_q;
`else
    assign mux_words = port_words;
    assign mux_sel   = Signal;
`endif

    // Selection: every 5-bit code picks exactly one word, passed unmodified.
    always_comb begin
        sel_word = mux_words[mux_sel];
    end

    // Output register: captures the selected word every cycle, zero on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            Output <= 32'h0000_0000;
        end else begin
            Output <= sel_word;
        end
    end

endmodule

// File: tb/tb_multiplex.sv
// tb_multiplex: directed bench for multiplex. Expected values are written
// from the one-hot input pattern (Rn = 1 << n) and the build's latency.
module tb_multiplex;

`ifdef MULTIPLEX_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] r [32];
    logic [4:0]  sig;
    logic [31:0] out_w;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected values in flight through the pipeline.
    logic [31:0] exp_q [$];

    multiplex dut (
        .clk(clk), .rst(rst),
        .R0(r[0]),   .R1(r[1]),   .R2(r[2]),   .R3(r[3]),
        .R4(r[4]),   .R5(r[5]),   .R6(r[6]),   .R7(r[7]),
        .R8(r[8]),   .R9(r[9]),   .R10(r[10]), .R11(r[11]),
        .R12(r[12]), .R13(r[13]), .R14(r[14]), .R15(r[15]),
        .R16(r[16]), .R17(r[17]), .R18(r[18]), .R19(r[19]),
        .R20(r[20]), .R21(r[21]), .R22(r[22]), .R23(r[23]),
        .R24(r[24]), .R25(r[25]), .R26(r[26]), .R27(r[27]),
        .R28(r[28]), .R29(r[29]), .R30(r[30]), .R31(r[31]),
        .Signal(sig),
        .Output(out_w)
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock with the currently driven inputs. exp_now is the word
    // the current inputs should select; it reaches Output after LAT edges.
    task automatic tick(input logic [31:0] exp_now, input string tag);
        if (rst) begin
            @(posedge clk);
            #1;
            check(out_w, 32'h0000_0000, tag);
            exp_q.delete();
            // A cleared input stage selects zero for the first cycle after release.
            for (int i = 0; i < LAT - 1; i++) exp_q.push_back(32'h0000_0000);
        end else begin
            exp_q.push_back(exp_now);
            @(posedge clk);
            #1;
            if (exp_q.size() >= LAT) check(out_w, exp_q.pop_front(), tag);
        end
    endtask

    task automatic load_one_hot();
        for (int n = 0; n < 32; n++) r[n] = 32'h1 << n;
    endtask

    initial begin
        load_one_hot();
        sig = 5'd7;

        // Reset held for 2 cycles with Signal = 7.
        rst = 1'b1;
        tick(32'h0, "reset_c0");
        tick(32'h0, "reset_c1");
        rst = 1'b0;
        for (int k = 0; k < LAT; k++) tick(32'h0000_0080, "reset_release_sel7");

        // Full sweep 0..31.
        for (int s = 0; s < 32; s++) begin
            sig = 5'(s);
            tick(32'h1 << s, "sweep");
        end

        // Wrap-around 30, 31, 0, 1.
        sig = 5'd30; tick(32'h4000_0000, "wrap_30");
        sig = 5'd31; tick(32'h8000_0000, "wrap_31");
        sig = 5'd0;  tick(32'h0000_0001, "wrap_0");
        sig = 5'd1;  tick(32'h0000_0002, "wrap_1");

        // Fixed select 5, change R5 then R6.
        sig = 5'd5;
        tick(32'h0000_0020, "sel5_orig");
        r[5] = 32'hDEAD_BEEF;
        tick(32'hDEAD_BEEF, "sel5_new_data");
        r[6] = 32'h1234_5678;
        tick(32'hDEAD_BEEF, "sel5_r6_change");
        for (int k = 0; k < LAT; k++) tick(32'hDEAD_BEEF, "sel5_hold");
        load_one_hot();

        // Sweep with a one-cycle reset pulse at Signal = 12.
        for (int s = 0; s < 32; s++) begin
            sig = 5'(s);
            if (s == 12) begin
                rst = 1'b1;
                tick(32'h0, "midreset_pulse");
                rst = 1'b0;
            end else begin
                tick(32'h1 << s, "midreset_sweep");
            end
        end

        // Glitch isolation: Signal 3 -> 9 -> 3 between edges.
        sig = 5'd3;
        #2 sig = 5'd9;
        #2 sig = 5'd3;
        tick(32'h0000_0008, "glitch_sel3");
        for (int k = 0; k < LAT; k++) tick(32'h0000_0008, "glitch_hold");

        // Random selections with one-hot data.
        for (int k = 0; k < 8; k++) begin
            sig = 5'($urandom_range(0, 31));
            tick(32'h1 << sig, "random_sel");
        end
        for (int k = 0; k < LAT; k++) tick(32'h1 << sig, "random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety bound on run time.
    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
